// File: rtl/texel_disassembler_if.sv
// Texel word protocol bus: texel record hand-off from the raster pipeline
// and the 32-bit push port into the AHB master write buffer.
interface texel_disassembler_if;
  logic [167:0] texel_buffer;
  logic         texel_ready;
  logic         texel_read;
  logic         ahb_buffer_full;
  logic         ahb_user_write_buffer;
  logic [31:0]  ahb_wbuffer;
  logic         busy;
  logic         frame_done;

  // Serializer side: consumes texel records, pushes words.
  modport master (
    input  texel_buffer,
    input  texel_ready,
    input  ahb_buffer_full,
    output texel_read,
    output ahb_user_write_buffer,
    output ahb_wbuffer,
    output busy,
    output frame_done
  );

  // Environment side: texel producer plus AHB write buffer.
  modport slave (
    output texel_buffer,
    output texel_ready,
    output ahb_buffer_full,
    input  texel_read,
    input  ahb_user_write_buffer,
    input  ahb_wbuffer,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/texel_disassembler.sv
// Texel disassembler: captures one 168-bit texel record and serializes it
// into a framed stream of 32-bit words (FRAME_START, 6 payload words LSW
// first with the last word zero-extended, FRAME_END) for the AHB write buffer.
module texel_disassembler #(
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  texel_disassembler_if.master  bus
);

  localparam int unsigned TEXEL_W   = 168;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = (TEXEL_W + WORD_W - 1) / WORD_W;
  localparam logic [2:0]  LAST_IDX  = 3'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    END
  } state_t;

  state_t               state;
  logic [2:0]           idx;
  logic [TEXEL_W-1:0]   hold;
  logic                 frame_done_q;
  logic                 push;
  logic                 accept;
  logic [WORD_W-1:0]    payload_word;

  // A word transfers on any edge where a frame is active and the buffer has room.
  always_comb begin
    push = (state != IDLE) && !bus.ahb_buffer_full;
  end

  // Records are only accepted from IDLE, and never while reset is held.
  always_comb begin
    accept = (state == IDLE) && bus.texel_ready && n_rst;
  end

  // Select the payload slice addressed by idx; the top slice carries only 8 live bits.
  always_comb begin
    payload_word = '0;
    case (idx)
      3'd0:    payload_word = hold[31:0];
      3'd1:    payload_word = hold[63:32];
      3'd2:    payload_word = hold[95:64];
      3'd3:    payload_word = hold[127:96];
      3'd4:    payload_word = hold[159:128];
      3'd5:    payload_word = {24'd0, hold[167:160]};
      default: payload_word = '0;
    endcase
  end

  // Drive the bus outputs from the registered state.
  always_comb begin
    bus.texel_read            = accept;
    bus.ahb_user_write_buffer = push;
    bus.busy                  = (state != IDLE);
    bus.frame_done            = frame_done_q;
    case (state)
      START:   bus.ahb_wbuffer = FRAME_START;
      DATA:    bus.ahb_wbuffer = payload_word;
      END:     bus.ahb_wbuffer = FRAME_END;
      default: bus.ahb_wbuffer = '0;
    endcase
  end

  // Frame sequencer: advances only on a transfer, so backpressure simply freezes it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      idx          <= '0;
      hold         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            hold  <= bus.texel_buffer;
            idx   <= '0;
            state <= START;
          end
        end
        START: begin
          if (push) begin
            idx   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= END;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        END: begin
          if (push) begin
            frame_done_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          idx   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_texel_disassembler.sv
// Directed testbench for texel_disassembler: framing, backpressure,
// back-to-back records, reset mid-frame and stalls on the marker words.
module tb_texel_disassembler;

  logic tb_clk;
  logic n_rst;
  int   checks;
  int   failures;

  logic [167:0] tex_a;
  logic [167:0] tex_b;
  logic [31:0]  exp_a [8];
  logic [31:0]  exp_b [8];

  texel_disassembler_if bus_if ();

  texel_disassembler #(
    .FRAME_START (32'd0),
    .FRAME_END   (32'd1)
  ) dut (
    .clk   (tb_clk),
    .n_rst (n_rst),
    .bus   (bus_if.master)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    bus_if.texel_ready = 1'b1;
    bus_if.texel_buffer = tex_a;
    bus_if.ahb_buffer_full = 1'b0;
    step;
    step;
    #1;
    checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL reset_texel_read got %b expected 0", bus_if.texel_read); end
    checks++; if (bus_if.ahb_user_write_buffer !== 1'b0) begin failures++; $display("FAIL reset_write got %b expected 0", bus_if.ahb_user_write_buffer); end
    checks++; if (bus_if.ahb_wbuffer !== 32'd0) begin failures++; $display("FAIL reset_wbuffer got %h expected 00000000", bus_if.ahb_wbuffer); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b expected 0", bus_if.frame_done); end
    bus_if.texel_ready = 1'b0;
    n_rst = 1'b1;
    step;
    #1;
    checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL idle_no_ready_read got %b expected 0", bus_if.texel_read); end
    step;
  endtask

  task automatic test_single_frame;
    bus_if.texel_buffer = tex_a;
    bus_if.texel_ready = 1'b1;
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL single_accept got %b expected 1", bus_if.texel_read); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got %b expected 0", bus_if.busy); end
    step;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) bus_if.texel_ready = 1'b0;
      #1;
      checks++; if (bus_if.ahb_user_write_buffer !== 1'b1) begin failures++; $display("FAIL single_write[%0d] got %b expected 1", k, bus_if.ahb_user_write_buffer); end
      checks++; if (bus_if.ahb_wbuffer !== exp_a[k]) begin failures++; $display("FAIL single_word[%0d] got %h expected %h", k, bus_if.ahb_wbuffer, exp_a[k]); end
      checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL single_read_busy[%0d] got %b expected 0", k, bus_if.texel_read); end
      checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL single_busy[%0d] got %b expected 1", k, bus_if.busy); end
      checks++; if (bus_if.frame_done !== 1'b0) begin failures++; $display("FAIL single_early_done[%0d] got %b expected 0", k, bus_if.frame_done); end
      step;
    end
    #1;
    checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL single_frame_done got %b expected 1", bus_if.frame_done); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL single_end_busy got %b expected 0", bus_if.busy); end
    checks++; if (bus_if.ahb_user_write_buffer !== 1'b0) begin failures++; $display("FAIL single_end_write got %b expected 0", bus_if.ahb_user_write_buffer); end
    step;
    #1;
    checks++; if (bus_if.frame_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got %b expected 0", bus_if.frame_done); end
    step;
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_w [11];
    exp_w = '{32'd0, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd5, 32'd6, 32'h000000AB, 32'd1};
    bus_if.texel_buffer = tex_a;
    bus_if.texel_ready = 1'b1;
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL bp_accept got %b expected 1", bus_if.texel_read); end
    step;
    bus_if.texel_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      bus_if.ahb_buffer_full = (c >= 2 && c <= 4);
      #1;
      checks++; if (bus_if.ahb_wbuffer !== exp_w[c]) begin failures++; $display("FAIL bp_word[%0d] got %h expected %h", c, bus_if.ahb_wbuffer, exp_w[c]); end
      checks++; if (bus_if.ahb_user_write_buffer !== !(c >= 2 && c <= 4)) begin failures++; $display("FAIL bp_write[%0d] got %b expected %b", c, bus_if.ahb_user_write_buffer, !(c >= 2 && c <= 4)); end
      checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL bp_busy[%0d] got %b expected 1", c, bus_if.busy); end
      step;
    end
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL bp_frame_done got %b expected 1", bus_if.frame_done); end
    step;
  endtask

  task automatic test_full_markers;
    logic [31:0] exp_w [12];
    exp_w = '{32'd0, 32'd0, 32'd0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'h000000AB, 32'd1, 32'd1, 32'd1};
    bus_if.texel_buffer = tex_a;
    bus_if.texel_ready = 1'b1;
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL mk_accept got %b expected 1", bus_if.texel_read); end
    step;
    bus_if.texel_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus_if.ahb_buffer_full = (c <= 1) || (c == 9) || (c == 10);
      #1;
      checks++; if (bus_if.ahb_wbuffer !== exp_w[c]) begin failures++; $display("FAIL mk_word[%0d] got %h expected %h", c, bus_if.ahb_wbuffer, exp_w[c]); end
      checks++; if (bus_if.ahb_user_write_buffer !== !((c <= 1) || (c == 9) || (c == 10))) begin failures++; $display("FAIL mk_write[%0d] got %b", c, bus_if.ahb_user_write_buffer); end
      checks++; if (bus_if.frame_done !== 1'b0) begin failures++; $display("FAIL mk_early_done[%0d] got %b expected 0", c, bus_if.frame_done); end
      step;
    end
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL mk_frame_done got %b expected 1", bus_if.frame_done); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL mk_end_busy got %b expected 0", bus_if.busy); end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w;
    int k;
    bus_if.texel_buffer = tex_a;
    bus_if.texel_ready = 1'b1;
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL b2b_accept0 got %b expected 1", bus_if.texel_read); end
    step;
    for (int c = 0; c < 17; c++) begin
      if (c == 3) bus_if.texel_buffer = tex_b;
      if (c == 12) bus_if.texel_buffer = tex_a;
      if (c == 16) bus_if.texel_ready = 1'b0;
      #1;
      if (c == 8) begin
        checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL b2b_accept1 got %b expected 1", bus_if.texel_read); end
        checks++; if (bus_if.ahb_user_write_buffer !== 1'b0) begin failures++; $display("FAIL b2b_gap_write got %b expected 0", bus_if.ahb_user_write_buffer); end
        checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done0 got %b expected 1", bus_if.frame_done); end
      end else begin
        k = (c < 8) ? c : c - 9;
        exp_w = (c < 8) ? exp_a[k] : exp_b[k];
        checks++; if (bus_if.ahb_user_write_buffer !== 1'b1) begin failures++; $display("FAIL b2b_write[%0d] got %b expected 1", c, bus_if.ahb_user_write_buffer); end
        checks++; if (bus_if.ahb_wbuffer !== exp_w) begin failures++; $display("FAIL b2b_word[%0d] got %h expected %h", c, bus_if.ahb_wbuffer, exp_w); end
        checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL b2b_read[%0d] got %b expected 0", c, bus_if.texel_read); end
      end
      step;
    end
    #1;
    checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got %b expected 1", bus_if.frame_done); end
    checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL b2b_no_third got %b expected 0", bus_if.texel_read); end
    checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got %b expected 0", bus_if.busy); end
    step;
  endtask

  task automatic test_reset_mid_frame;
    bus_if.texel_buffer = tex_a;
    bus_if.texel_ready = 1'b1;
    bus_if.ahb_buffer_full = 1'b0;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL rmf_accept got %b expected 1", bus_if.texel_read); end
    step;
    bus_if.texel_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus_if.ahb_wbuffer !== exp_a[c]) begin failures++; $display("FAIL rmf_word[%0d] got %h expected %h", c, bus_if.ahb_wbuffer, exp_a[c]); end
      step;
    end
    n_rst = 1'b0;
    bus_if.texel_ready = 1'b1;
    #1;
    checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL rmf_read_in_reset got %b expected 0", bus_if.texel_read); end
    step;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL rmf_busy[%0d] got %b expected 0", c, bus_if.busy); end
      checks++; if (bus_if.ahb_user_write_buffer !== 1'b0) begin failures++; $display("FAIL rmf_write[%0d] got %b expected 0", c, bus_if.ahb_user_write_buffer); end
      checks++; if (bus_if.ahb_wbuffer !== 32'd0) begin failures++; $display("FAIL rmf_wbuffer[%0d] got %h expected 00000000", c, bus_if.ahb_wbuffer); end
      checks++; if (bus_if.texel_read !== 1'b0) begin failures++; $display("FAIL rmf_read[%0d] got %b expected 0", c, bus_if.texel_read); end
      checks++; if (bus_if.frame_done !== 1'b0) begin failures++; $display("FAIL rmf_done[%0d] got %b expected 0", c, bus_if.frame_done); end
      step;
    end
    n_rst = 1'b1;
    bus_if.texel_buffer = tex_b;
    #1;
    checks++; if (bus_if.texel_read !== 1'b1) begin failures++; $display("FAIL rmf_reaccept got %b expected 1", bus_if.texel_read); end
    step;
    bus_if.texel_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (bus_if.ahb_user_write_buffer !== 1'b1) begin failures++; $display("FAIL rmf_new_write[%0d] got %b expected 1", c, bus_if.ahb_user_write_buffer); end
      checks++; if (bus_if.ahb_wbuffer !== exp_b[c]) begin failures++; $display("FAIL rmf_new_word[%0d] got %h expected %h", c, bus_if.ahb_wbuffer, exp_b[c]); end
      step;
    end
    #1;
    checks++; if (bus_if.frame_done !== 1'b1) begin failures++; $display("FAIL rmf_frame_done got %b expected 1", bus_if.frame_done); end
    step;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    tex_a = {8'hAB, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2};
    tex_b = {8'h5C, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 32'h13579BDF};
    exp_a = '{32'd0, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'h000000AB, 32'd1};
    exp_b = '{32'd0, 32'h13579BDF, 32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF, 32'h0000005C, 32'd1};
    n_rst = 1'b0;
    bus_if.texel_buffer = '0;
    bus_if.texel_ready = 1'b0;
    bus_if.ahb_buffer_full = 1'b0;

    test_reset;
    test_single_frame;
    test_backpressure;
    test_full_markers;
    test_back_to_back;
    test_reset_mid_frame;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
